// File: rtl/tsm_ahb_regbridge.sv
`timescale 1ns/1ps
// tsm_ahb_regbridge: AHB-Lite slave bridging to the sysreg/MAC register port,
// fixed-latency on reg_hit, otherwise waits for mac_ack with a timeout ERROR.
module tsm_ahb_regbridge #(
  parameter int TIMEOUT_CYC = 64,
  parameter bit ERR_ON_SIZE = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADYIN,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_cs_n,
  output logic        reg_wr_n,
  input  logic [31:0] reg_rdata,
  input  logic        reg_hit,
  input  logic        mac_ack
);
  localparam logic [2:0] IDLE = 3'd0, CAPT = 3'd1, STROBE = 3'd2, WAIT = 3'd3, ERR1 = 3'd4, ERR2 = 3'd5;
  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYC);
  logic [2:0] state;
  logic [7:0] count;
  logic isWrite;
  logic accept;
  logic sizeBad;
  logic done;
  logic unusedBits;
  assign unusedBits = ^{HADDR[31:7], HTRANS[0]};
  assign accept = HSEL & HREADYIN & HTRANS[1] & ((state == IDLE) | (state == ERR2));
  assign sizeBad = ERR_ON_SIZE & ((HSIZE != 3'b010) | (HADDR[1:0] != 2'b00));
  // A sysreg hit wins over mac_ack; in WAIT only mac_ack can finish the access.
  assign done = ((state == STROBE) & (reg_hit | mac_ack)) | ((state == WAIT) & mac_ack);
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= IDLE;
      count     <= 8'd0;
      isWrite   <= 1'b0;
      HRDATA    <= 32'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      reg_addr  <= 5'd0;
      reg_wdata <= 32'd0;
      reg_cs_n  <= 1'b1;
      reg_wr_n  <= 1'b1;
    end else begin
      case (state)
        IDLE, ERR2: begin
          HREADYOUT <= !accept;
          HRESP     <= accept & sizeBad;
          state     <= accept ? (sizeBad ? ERR1 : CAPT) : IDLE;
          if (accept) begin
            reg_addr <= HADDR[6:2];
            isWrite  <= HWRITE;
          end
        end
        CAPT: begin
          if (isWrite) reg_wdata <= HWDATA;
          reg_cs_n <= 1'b0;
          reg_wr_n <= !isWrite;
          state    <= STROBE;
        end
        STROBE, WAIT: begin
          if (done) begin
            HRDATA    <= isWrite ? 32'd0 : reg_rdata;
            HREADYOUT <= 1'b1;
            reg_cs_n  <= 1'b1;
            reg_wr_n  <= 1'b1;
            count     <= 8'd0;
            state     <= IDLE;
          end else if (state == STROBE) begin
            count <= 8'd1;
            state <= WAIT;
          end else if (count == TIMEOUT) begin
            reg_cs_n <= 1'b1;
            reg_wr_n <= 1'b1;
            HRESP    <= 1'b1;
            count    <= 8'd0;
            state    <= ERR1;
          end else if (count != 8'hFF) begin
            count <= count + 8'd1;
          end
        end
        ERR1: begin
          HREADYOUT <= 1'b1;
          state     <= ERR2;
        end
        default: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          reg_cs_n  <= 1'b1;
          reg_wr_n  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
